// File: rtl/add_round_key_seq_if.sv
// Bus bundle for add_round_key_seq: key-table write port, input stream,
// output stream and status. The slave modport is the block's view; the
// master modport is the environment's view.
interface add_round_key_seq_if #(
  parameter int DATA_W   = 128,
  parameter int NUM_KEYS = 11,
  parameter int ADDR_W   = 4
);
  // Key table write port
  logic              key_wr_en;
  logic [ADDR_W-1:0] key_wr_addr;
  logic [DATA_W-1:0] key_wr_data;
  logic              key_clear;

  // Handshake rule for both streams: a transfer happens on a rising edge
  // where valid and ready are both high. The producer holds its payload
  // stable while valid is high and ready is low. in_ready depends only on
  // out_valid and out_ready, never on in_valid, so no combinational loop
  // can form through the block.
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [ADDR_W-1:0] in_round;
  logic              in_decrypt;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_key_miss;

  // Status
  logic [NUM_KEYS-1:0] key_loaded;
  logic [15:0]         blk_count;

  modport slave (
    input  key_wr_en, key_wr_addr, key_wr_data, key_clear,
    input  in_valid, in_data, in_round, in_decrypt,
    output in_ready,
    output out_valid, out_data, out_key_miss,
    input  out_ready,
    output key_loaded, blk_count
  );

  modport master (
    output key_wr_en, key_wr_addr, key_wr_data, key_clear,
    output in_valid, in_data, in_round, in_decrypt,
    input  in_ready,
    input  out_valid, out_data, out_key_miss,
    output out_ready,
    input  key_loaded, blk_count
  );
endinterface

// File: rtl/add_round_key_seq.sv
// AES AddRoundKey stage with an on-chip round-key table.
// Each accepted block is XORed with the key selected by its round number
// (reversed order for decryption) and held in a one-deep output register.
// Unloaded or out-of-range keys pass the data through and flag a miss.
module add_round_key_seq #(
  parameter int DATA_W   = 128,
  parameter int NUM_KEYS = 11,
  parameter int ADDR_W   = 4
) (
  input logic                clk,
  input logic                rst,
  add_round_key_seq_if.slave bus
);

  localparam int IDX_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam logic [ADDR_W:0]  NK_EXT   = (ADDR_W + 1)'(NUM_KEYS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_KEYS - 1);

  // Key storage is deliberately left unreset; key_loaded_q alone decides
  // whether a slot may be used.
  logic [DATA_W-1:0]   key_mem_q [NUM_KEYS];
  logic [NUM_KEYS-1:0] key_loaded_q;

  logic                out_valid_q;
  logic [DATA_W-1:0]   out_data_q;
  logic                out_key_miss_q;
  logic [15:0]         blk_count_q;

  logic                accept;
  logic                round_ok;
  logic [IDX_W-1:0]    slot_idx;
  logic [DATA_W-1:0]   sel_key;
  logic                key_hit;
  logic                wr_ok;
  logic [IDX_W-1:0]    wr_idx;

  assign bus.in_ready     = !out_valid_q || bus.out_ready;
  assign accept           = bus.in_valid && bus.in_ready;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_data_q;
  assign bus.out_key_miss = out_key_miss_q;
  assign bus.key_loaded   = key_loaded_q;
  assign bus.blk_count    = blk_count_q;

  // Key selection: range-check the logical round, then map it to a slot.
  // Reading the table combinationally means a same-cycle write is seen only
  // from the next edge onward, so the old key and flag are used.
  always_comb begin
    round_ok = ({1'b0, bus.in_round} < NK_EXT);
    slot_idx = bus.in_decrypt ? (LAST_IDX - bus.in_round[IDX_W-1:0])
                              : bus.in_round[IDX_W-1:0];
    sel_key  = '0;
    key_hit  = 1'b0;
    if (round_ok) begin
      sel_key = key_mem_q[slot_idx];
      key_hit = key_loaded_q[slot_idx];
    end
  end

  // Write-address decode; addresses beyond the table are dropped.
  always_comb begin
    wr_ok  = ({1'b0, bus.key_wr_addr} < NK_EXT);
    wr_idx = bus.key_wr_addr[IDX_W-1:0];
  end

  // Key table contents: plain storage, no reset. A clear cycle does not
  // write, since the slot is about to be marked unloaded anyway.
  always_ff @(posedge clk) begin
    if (bus.key_wr_en && wr_ok && !bus.key_clear) begin
      key_mem_q[wr_idx] <= bus.key_wr_data;
    end
  end

  // Per-slot loaded flags: clear dominates a simultaneous write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_loaded_q <= '0;
    end else if (bus.key_clear) begin
      key_loaded_q <= '0;
    end else if (bus.key_wr_en && wr_ok) begin
      key_loaded_q[wr_idx] <= 1'b1;
    end
  end

  // One-deep output register: load on accept, drain when consumed,
  // otherwise hold the result stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      out_key_miss_q <= 1'b0;
    end else if (accept) begin
      out_valid_q    <= 1'b1;
      out_data_q     <= key_hit ? (bus.in_data ^ sel_key) : bus.in_data;
      out_key_miss_q <= !key_hit;
    end else if (bus.out_ready) begin
      out_valid_q    <= 1'b0;
    end
  end

  // Accepted-block counter, saturating at all ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_count_q <= '0;
    end else if (accept && (blk_count_q != 16'hFFFF)) begin
      blk_count_q <= blk_count_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_add_round_key_seq.sv
// Randomized scoreboard bench for add_round_key_seq.
module tb_add_round_key_seq;

  localparam int DW = 128;
  localparam int AW = 4;
  localparam int NK = 11;

  logic clk;
  logic rst;

  add_round_key_seq_if #(.DATA_W(DW), .NUM_KEYS(NK), .ADDR_W(AW)) bus ();

  add_round_key_seq #(.DATA_W(DW), .NUM_KEYS(NK), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  logic [DW-1:0] m_key [NK];
  logic          m_loaded [NK];
  logic          m_ov;
  int            m_cnt;

  logic [DW:0]   exp_q[$];
  int            checks = 0;
  int            errors = 0;

  task automatic model_reset();
    for (int i = 0; i < NK; i++) m_loaded[i] = 1'b0;
    m_ov  = 1'b0;
    m_cnt = 0;
    exp_q.delete();
  endtask

  function automatic logic [NK-1:0] model_loaded_vec();
    logic [NK-1:0] v;
    for (int i = 0; i < NK; i++) v[i] = m_loaded[i];
    return v;
  endfunction

  // {miss, data} expected for one block, from the current key table.
  function automatic logic [DW:0] expect_of(input logic [DW-1:0] d,
                                            input int r, input logic dec);
    int slot;
    if (r >= NK) return {1'b1, d};
    slot = dec ? (NK - 1 - r) : r;
    if (!m_loaded[slot]) return {1'b1, d};
    return {1'b0, d ^ m_key[slot]};
  endfunction

  task automatic chk(input string name, input logic [DW:0] act,
                     input logic [DW:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // One clock cycle: drive after the edge, check at the falling edge, then
  // advance the model as the coming rising edge will.
  task automatic cycle(input logic v, input logic [DW-1:0] d, input int r,
                       input logic dec, input logic ordy,
                       input logic we, input int wa, input logic [DW-1:0] wd,
                       input logic clr, output logic acc);
    @(posedge clk);
    #1;
    bus.in_valid    = v;
    bus.in_data     = d;
    bus.in_round    = AW'(r);
    bus.in_decrypt  = dec;
    bus.out_ready   = ordy;
    bus.key_wr_en   = we;
    bus.key_wr_addr = AW'(wa);
    bus.key_wr_data = wd;
    bus.key_clear   = clr;
    @(negedge clk);
    chk("in_ready",   {128'd0, bus.in_ready},  {128'd0, (!m_ov || ordy)});
    chk("out_valid",  {128'd0, bus.out_valid}, {128'd0, m_ov});
    chk("key_loaded", (DW+1)'(bus.key_loaded), (DW+1)'(model_loaded_vec()));
    chk("blk_count",  (DW+1)'(bus.blk_count),  (DW+1)'(m_cnt));
    acc = v && (!m_ov || ordy);
    if (acc) begin
      exp_q.push_back(expect_of(d, r, dec));
      if (m_cnt != 65535) m_cnt++;
      m_ov = 1'b1;
    end else if (ordy) begin
      m_ov = 1'b0;
    end
    if (clr) begin
      for (int i = 0; i < NK; i++) m_loaded[i] = 1'b0;
    end else if (we && wa < NK) begin
      m_key[wa]    = wd;
      m_loaded[wa] = 1'b1;
    end
  endtask

  task automatic idle(input logic ordy);
    logic a;
    cycle(1'b0, '0, 0, 1'b0, ordy, 1'b0, 0, '0, 1'b0, a);
  endtask

  task automatic send(input logic [DW-1:0] d, input int r, input logic dec);
    logic a;
    cycle(1'b1, d, r, dec, 1'b1, 1'b0, 0, '0, 1'b0, a);
  endtask

  task automatic wkey(input int wa, input logic [DW-1:0] wd);
    logic a;
    cycle(1'b0, '0, 0, 1'b0, 1'b1, 1'b1, wa, wd, 1'b0, a);
  endtask

  function automatic logic [DW-1:0] rand_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- monitor ----------------
  logic [DW:0] mon_exp;
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_unexpected: got %h expected no output",
                 {bus.out_key_miss, bus.out_data});
      end else begin
        mon_exp = exp_q.pop_front();
        chk("out_result", {bus.out_key_miss, bus.out_data}, mon_exp);
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [DW-1:0] k, blk [4];
  logic [DW:0]   held;
  logic          a;
  int            i, cyc;

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_round = '0;
    bus.in_decrypt = 1'b0; bus.out_ready = 1'b0; bus.key_wr_en = 1'b0;
    bus.key_wr_addr = '0; bus.key_wr_data = '0; bus.key_clear = 1'b0;
    model_reset();
    @(posedge clk); #2;
    chk("rst_out_valid",  {128'd0, bus.out_valid},    '0);
    chk("rst_out_data",   {1'b0, bus.out_data},       '0);
    chk("rst_miss",       {128'd0, bus.out_key_miss}, '0);
    chk("rst_key_loaded", (DW+1)'(bus.key_loaded),    '0);
    chk("rst_blk_count",  (DW+1)'(bus.blk_count),     '0);
    chk("rst_in_ready",   {128'd0, bus.in_ready},     (DW+1)'(1));
    @(negedge clk); #2;
    rst = 1'b0;

    // Known-answer vector on slot 0.
    wkey(0, 128'h000102030405060708090a0b0c0d0e0f);
    send(128'h00112233445566778899aabbccddeeff, 0, 1'b0);
    idle(1'b0);
    chk("kat_data", {1'b0, bus.out_data},
        {1'b0, 128'h00102030405060708090a0b0c0d0e0f0});
    chk("kat_miss", {128'd0, bus.out_key_miss}, '0);
    idle(1'b1);

    // Decrypt ordering uses slot 10; encrypt round 0 misses once cleared.
    cycle(1'b0, '0, 0, 1'b0, 1'b1, 1'b0, 0, '0, 1'b1, a);
    k = rand_blk();
    wkey(10, k);
    send(rand_blk(), 0, 1'b1);
    send(rand_blk(), 0, 1'b0);
    send(rand_blk(), 10, 1'b1);
    idle(1'b1); idle(1'b1);

    // Stall: 4 blocks, downstream not ready for 3 cycles after the first.
    rst = 1'b1; #2; rst = 1'b0; model_reset();
    wkey(5, rand_blk());
    for (int j = 0; j < 4; j++) blk[j] = rand_blk();
    held = expect_of(blk[0], 5, 1'b0);
    i = 0; cyc = 0;
    while (i < 4 && cyc < 20) begin
      cycle(1'b1, blk[i], 5, 1'b0, !(cyc >= 1 && cyc <= 3),
            1'b0, 0, '0, 1'b0, a);
      if (cyc >= 1 && cyc <= 3)
        chk("stall_hold", {bus.out_key_miss, bus.out_data}, held);
      if (a) i++;
      cyc++;
    end
    chk("stream_done", (DW+1)'(i), (DW+1)'(4));
    idle(1'b1); idle(1'b1);
    chk("stream_count", (DW+1)'(bus.blk_count), (DW+1)'(4));

    // Same-cycle write and read of slot 3: old key first, new key next.
    wkey(3, rand_blk());
    cycle(1'b1, rand_blk(), 3, 1'b0, 1'b1, 1'b1, 3, rand_blk(), 1'b0, a);
    send(rand_blk(), 3, 1'b0);
    idle(1'b1); idle(1'b1);

    // Clear beats write; out-of-range rounds pass through with a miss.
    wkey(2, rand_blk());
    cycle(1'b0, '0, 0, 1'b0, 1'b1, 1'b1, 2, rand_blk(), 1'b1, a);
    idle(1'b1);
    chk("clear_wins", (DW+1)'(bus.key_loaded), '0);
    wkey(0, rand_blk());
    send(rand_blk(), 11, 1'b0);
    send(rand_blk(), 15, 1'b1);
    wkey(12, rand_blk());
    idle(1'b1); idle(1'b1);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      cycle($urandom_range(0, 3) != 0, rand_blk(), $urandom_range(0, 13),
            1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 15), rand_blk(),
            $urandom_range(0, 40) == 0, a);
    end
    for (int n = 0; n < 3; n++) idle(1'b1);

    // Asynchronous reset while a result is held.
    wkey(1, rand_blk());
    cycle(1'b1, rand_blk(), 1, 1'b0, 1'b0, 1'b0, 0, '0, 1'b0, a);
    idle(1'b0);
    chk("pre_rst_valid", {128'd0, bus.out_valid}, (DW+1)'(1));
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid",  {128'd0, bus.out_valid},  '0);
    chk("arst_key_loaded", (DW+1)'(bus.key_loaded),  '0);
    chk("arst_blk_count",  (DW+1)'(bus.blk_count),   '0);
    chk("arst_out_data",   {1'b0, bus.out_data},     '0);
    chk("arst_in_ready",   {128'd0, bus.in_ready},   (DW+1)'(1));
    model_reset();
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b0;
    wkey(1, rand_blk());
    send(rand_blk(), 1, 1'b0);
    send(rand_blk(), 9, 1'b1);
    idle(1'b1); idle(1'b1);

    chk("queue_empty", (DW+1)'(exp_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/add_round_key_seq.md
ADD_ROUND_KEY_SEQ -- requirements
Module: add_round_key_seq

Interface
REQ-001 Parameter DATA_W, default 128, state/key width in bits; SHALL be a multiple of 8.
REQ-002 Parameter NUM_KEYS, default 11, number of round-key slots (AES-128: rounds 0..10).
REQ-003 Parameter ADDR_W, default 4, slot/round index width; SHALL satisfy 2^ADDR_W >= NUM_KEYS.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 key_wr_en  input  1  write key_wr_data into slot key_wr_addr.
REQ-007 key_wr_addr  input  ADDR_W  target slot.
REQ-008 key_wr_data  input  DATA_W  round key.
REQ-009 key_clear  input  1  invalidate all slots.
REQ-010 in_valid  input  1  input block present.
REQ-011 in_ready  output  1  block can accept input this cycle.
REQ-012 in_data  input  DATA_W  state to combine.
REQ-013 in_round  input  ADDR_W  logical round number.
REQ-014 in_decrypt  input  1  1 = decrypt key ordering.
REQ-015 out_valid  output  1  result held in output register.
REQ-016 out_ready  input  1  downstream accepts result.
REQ-017 out_data  output  DATA_W  in_data XOR selected key.
REQ-018 out_key_miss  output  1  selected slot out of range or unloaded; qualified by out_valid.
REQ-019 key_loaded  output  NUM_KEYS  per-slot loaded flag.
REQ-020 blk_count  output  16  count of accepted input blocks.

Function
REQ-021 in_ready SHALL equal !out_valid || out_ready (combinational; one-deep output register).
REQ-022 Accept SHALL occur on a rising edge where in_valid && in_ready; exactly one block per accept.
REQ-023 Slot index SHALL be in_round when in_decrypt=0, NUM_KEYS-1-in_round when in_decrypt=1.
REQ-024 On accept with in_round < NUM_KEYS and slot loaded: out_data <= in_data ^ key[slot], out_key_miss <= 0.
REQ-025 On accept with in_round >= NUM_KEYS or slot not loaded: out_data <= in_data unchanged, out_key_miss <= 1.
REQ-026 Latency SHALL be 1 cycle: out_valid=1 the cycle after accept.
REQ-027 While out_valid && !out_ready, out_data and out_key_miss SHALL hold stable and no accept occurs.
REQ-028 out_valid clears after a cycle with out_ready=1 and no simultaneous accept; accept with out_ready=1 keeps out_valid=1 (full throughput, one block/cycle).
REQ-029 Key write with key_wr_addr < NUM_KEYS SHALL store data and set key_loaded[addr]; addr >= NUM_KEYS SHALL be ignored.
REQ-030 Key write and accept reading the same slot in one cycle: XOR SHALL use the slot contents before the write (old key, old loaded flag).
REQ-031 key_clear SHALL zero key_loaded on the next edge; key_clear wins over a simultaneous key_wr_en.
REQ-032 Key storage contents SHALL not be reset; only key_loaded governs use.
REQ-033 blk_count SHALL increment by 1 per accept and saturate at 16'hFFFF.
REQ-034 No data-dependent stall: key writes and key_clear never affect in_ready.

Reset
REQ-035 rst=1 SHALL immediately force out_valid=0, out_data=0, out_key_miss=0, key_loaded=0, blk_count=0.
REQ-036 Reset mid-transfer SHALL discard the held result; first accept after deassertion behaves as from power-up.
REQ-037 in_ready SHALL read 1 during and after reset (out_valid=0).

Verification
REQ-038 Load slot 0 = 000102030405060708090a0b0c0d0e0f; accept in_data=00112233445566778899aabbccddeeff, round 0, encrypt -> next cycle out_data=00102030405060708090a0b0c0d0e0f0, miss=0.
REQ-039 Load slot 10 = K; accept round 0, in_decrypt=1 -> out_data=in_data^K; same with in_decrypt=0 and slot 0 unloaded -> out_data=in_data, miss=1.
REQ-040 Stream 4 blocks with out_ready=0 for 3 cycles after first -> out_data held, in_ready=0 throughout stall, all 4 results delivered in order, blk_count=4.
REQ-041 Same-cycle write slot 3 (new key) and accept round 3 -> result uses old key; next accept round 3 uses new key.
REQ-042 key_clear with simultaneous write slot 2 -> key_loaded=0; in_round=11 -> miss=1, data passed through.
REQ-043 Assert rst while out_valid=1 and out_ready=0 -> out_valid=0, key_loaded=0, blk_count=0 without waiting for clk.
